// File: rtl/flight_timer_programmer.sv
// Datapin pulse-train transmitter: emits REPEAT high pulses of prog_value cycles, each framed by GAP_CYCLES lows.
// Optional FLIGHT_PROG_ABORT_EN adds an abort input that truncates the train into a final gap.
module flight_timer_programmer #(
    parameter int WIDTH      = 16,
    parameter int GAP_CYCLES = 4,
    parameter int REPEAT     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] prog_value,
`ifdef FLIGHT_PROG_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             datapin
);

    localparam int PW = $clog2(REPEAT + 1);
    localparam logic [WIDTH-1:0] GAP_LOAD = WIDTH'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRE_GAP,
        HIGH,
        GAP,
        FINISH
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] value_q, value_nx;
    logic [WIDTH-1:0] cnt_q, cnt_nx;
    logic [PW-1:0]    pulses_q, pulses_nx;
    logic             err_nx;
    logic             abort_req;
    logic             in_train;

`ifdef FLIGHT_PROG_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign in_train = (state == PRE_GAP) || (state == HIGH) || (state == GAP);

    // cnt_q holds "cycles remaining minus one" in the current phase, so a
    // full-scale prog_value loads 2^WIDTH-2 and never wraps.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would otherwise infer a latch.
        state_nx  = state;
        value_nx  = value_q;
        cnt_nx    = cnt_q;
        pulses_nx = pulses_q;
        err_nx    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (prog_value != '0) begin
                        state_nx  = PRE_GAP;
                        value_nx  = prog_value;
                        pulses_nx = PW'(REPEAT);
                        cnt_nx    = GAP_LOAD;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            PRE_GAP: begin
                if (cnt_q == '0) begin
                    state_nx = HIGH;
                    cnt_nx   = value_q - 1'b1;
                end else begin
                    cnt_nx = cnt_q - 1'b1;
                end
            end
            HIGH: begin
                if (cnt_q == '0) begin
                    state_nx  = GAP;
                    cnt_nx    = GAP_LOAD;
                    pulses_nx = pulses_q - 1'b1;
                end else begin
                    cnt_nx = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (cnt_q != '0) begin
                    cnt_nx = cnt_q - 1'b1;
                end else if (pulses_q != '0) begin
                    state_nx = HIGH;
                    cnt_nx   = value_q - 1'b1;
                end else begin
                    state_nx = FINISH;
                end
            end
            FINISH: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase

        // Abort overrides any phase of the train with one full closing gap.
        if (abort_req && in_train) begin
            state_nx  = GAP;
            cnt_nx    = GAP_LOAD;
            pulses_nx = '0;
        end
    end

    // Outputs are registered from the next-state decode so each one is a flop
    // that lines up exactly with the state it reports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            value_q  <= '0;
            cnt_q    <= '0;
            pulses_q <= '0;
            datapin  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state    <= state_nx;
            value_q  <= value_nx;
            cnt_q    <= cnt_nx;
            pulses_q <= pulses_nx;
            datapin  <= (state_nx == HIGH);
            busy     <= (state_nx == PRE_GAP) || (state_nx == HIGH) || (state_nx == GAP);
            done     <= (state_nx == FINISH);
            err      <= err_nx;
        end
    end

endmodule

// File: tb/tb_flight_timer_programmer.sv
// Self-checking bench: three parameterisations compared cycle by cycle against a waveform model
// built from the pulse-train rules; abort scenario runs when FLIGHT_PROG_ABORT_EN is defined.
module tb_flight_timer_programmer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    logic [15:0] prog0 = '0;
    logic [7:0]  prog1 = '0;
    logic [4:0]  prog2 = '0;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic        err0, err1, err2;
    logic        dp0, dp1, dp2;
`ifdef FLIGHT_PROG_ABORT_EN
    logic        abort0 = 1'b0, abort1 = 1'b0, abort2 = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    flight_timer_programmer #(.WIDTH(16), .GAP_CYCLES(4), .REPEAT(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .prog_value(prog0),
`ifdef FLIGHT_PROG_ABORT_EN
        .abort(abort0),
`endif
        .busy(busy0), .done(done0), .err(err0), .datapin(dp0));

    flight_timer_programmer #(.WIDTH(8), .GAP_CYCLES(1), .REPEAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .prog_value(prog1),
`ifdef FLIGHT_PROG_ABORT_EN
        .abort(abort1),
`endif
        .busy(busy1), .done(done1), .err(err1), .datapin(dp1));

    flight_timer_programmer #(.WIDTH(5), .GAP_CYCLES(2), .REPEAT(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .prog_value(prog2),
`ifdef FLIGHT_PROG_ABORT_EN
        .abort(abort2),
`endif
        .busy(busy2), .done(done2), .err(err2), .datapin(dp2));

    function automatic int gap_of(input int sel);
        case (sel)
            0: return 4;
            1: return 1;
            default: return 2;
        endcase
    endfunction

    function automatic int rep_of(input int sel);
        case (sel)
            0: return 2;
            1: return 1;
            default: return 3;
        endcase
    endfunction

    function automatic int maxp_of(input int sel);
        case (sel)
            0: return 40;
            1: return 255;
            default: return 31;
        endcase
    endfunction

    // Observed vector {busy, datapin, done, err}.
    function automatic logic [3:0] obs(input int sel);
        case (sel)
            0: return {busy0, dp0, done0, err0};
            1: return {busy1, dp1, done1, err1};
            default: return {busy2, dp2, done2, err2};
        endcase
    endfunction

    task automatic drive(input int sel, input logic s, input int p, input logic ab);
        case (sel)
            0: begin start0 = s; prog0 = 16'(p); end
            1: begin start1 = s; prog1 = 8'(p); end
            default: begin start2 = s; prog2 = 5'(p); end
        endcase
`ifdef FLIGHT_PROG_ABORT_EN
        case (sel)
            0: abort0 = ab;
            1: abort1 = ab;
            default: abort2 = ab;
        endcase
`else
        if (ab) $display("note: abort request ignored in this build");
`endif
    endtask

    // noise: 0 quiet, 1 random start/prog while busy, 2 start=1 prog=9 while busy.
    // abort_at: >0 aborts on that high cycle of the first pulse.
    task automatic run_txn(input string name, input int sel, input int p,
                           input int noise, input int abort_at);
        logic [3:0] exp_q[$];
        int g = gap_of(sel);
        int r = rep_of(sel);
        int fin;
        logic [3:0] got;
        logic s_n, ab_n;
        int p_n;

        for (int i = 0; i < g; i++) exp_q.push_back(4'b1000);
        for (int k = 0; k < r; k++) begin
            if (abort_at > 0) begin
                for (int i = 0; i < abort_at; i++) exp_q.push_back(4'b1100);
                for (int i = 0; i < g; i++) exp_q.push_back(4'b1000);
                break;
            end
            for (int i = 0; i < p; i++) exp_q.push_back(4'b1100);
            for (int i = 0; i < g; i++) exp_q.push_back(4'b1000);
        end
        if (abort_at == 0 && exp_q.size() != g + r * (p + g))
            $display("note: model busy length %0d", exp_q.size());
        fin = exp_q.size();
        exp_q.push_back(4'b0010);
        for (int i = 0; i < 3; i++) exp_q.push_back(4'b0000);

        @(negedge clk);
        drive(sel, 1'b1, p, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            got = obs(sel);
            checks++;
            if (got !== exp_q[i]) begin
                errors++;
                $display("FAIL %s sel=%0d p=%0d cycle %0d: {busy,dp,done,err} got %b expected %b",
                         name, sel, p, i, got, exp_q[i]);
            end
            s_n  = 1'b0;
            p_n  = int'($urandom_range(0, maxp_of(sel)));
            ab_n = (abort_at > 0) && (i == g + abort_at - 1);
            if (i <= fin) begin
                if (noise == 1) s_n = 1'($urandom_range(0, 1));
                if (noise == 2) begin s_n = 1'b1; p_n = 9; end
            end
            drive(sel, s_n, p_n, ab_n);
        end
        drive(sel, 1'b0, 0, 1'b0);
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (obs(s) !== 4'b0000) begin
                errors++;
                $display("FAIL reset sel=%0d: got %b expected 0000", s, obs(s));
            end
        end
    endtask

    task automatic test_basic();
        run_txn("basic_p5", 0, 5, 0, 0);
    endtask

    task automatic test_zero_value();
        logic [3:0] exp_v[3] = '{4'b0001, 4'b0000, 4'b0000};
        @(negedge clk);
        drive(0, 1'b1, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(0, 1'b0, 0, 1'b0);
            checks++;
            if (obs(0) !== exp_v[i]) begin
                errors++;
                $display("FAIL zero_value cycle %0d: got %b expected %b", i, obs(0), exp_v[i]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        run_txn("start_while_busy", 0, 3, 2, 0);
    endtask

    task automatic test_reset_mid_pulse();
        @(negedge clk);
        drive(0, 1'b1, 6, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(0, 1'b0, 0, 1'b0);
        end
        checks++;
        if (obs(0) !== 4'b1100) begin
            errors++;
            $display("FAIL reset_mid_pulse pre: got %b expected 1100", obs(0));
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (obs(0) !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_pulse async: got %b expected 0000", obs(0));
        end
        @(negedge clk);
        checks++;
        if (obs(0) !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_pulse held: got %b expected 0000", obs(0));
        end
        rst_n = 1'b1;
        run_txn("after_reset_p2", 0, 2, 0, 0);
    endtask

    task automatic test_boundary();
        run_txn("min_g1_r1_p1", 1, 1, 0, 0);
        run_txn("w8_p255", 1, 255, 0, 0);
        run_txn("w5_p31", 2, 31, 1, 0);
        run_txn("w5_p1", 2, 1, 0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            int sel = int'($urandom_range(0, 2));
            int p   = int'($urandom_range(1, maxp_of(sel)));
            run_txn("random", sel, p, 1, 0);
        end
    endtask

`ifdef FLIGHT_PROG_ABORT_EN
    task automatic test_abort();
        run_txn("abort_p10", 0, 10, 0, 3);
        run_txn("abort_r3", 2, 7, 0, 1);
    endtask
`endif

    initial begin
        #2;
        test_reset();
        #20 rst_n = 1'b1;
        test_basic();
        test_zero_value();
        test_start_while_busy();
        test_reset_mid_pulse();
        test_boundary();
        test_random();
`ifdef FLIGHT_PROG_ABORT_EN
        test_abort();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
